// File: rtl/comparator_pkg.sv
// Shared types and helpers for the registered magnitude comparator.
// Signed operand mode is selected with the COMPARATOR_SIGNED_EN macro.
package comparator_pkg;

    localparam int COMPARATOR_DEFAULT_WIDTH = 3;

    typedef struct packed {
        logic gt;
        logic ge;
        logic lt;
        logic le;
        logic eq;
        logic ne;
    } cmp_flags_t;

    localparam cmp_flags_t CMP_FLAGS_CLEAR = '0;

    // The whole predicate set follows from gt and eq alone.
    function automatic cmp_flags_t derive_flags(input logic gt, input logic eq);
        cmp_flags_t f;
        f.gt = gt;
        f.ge = gt | eq;
        f.lt = ~(gt | eq);
        f.le = ~gt;
        f.eq = eq;
        f.ne = ~eq;
        return f;
    endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational gt/eq core for WIDTH-bit operands.
// COMPARATOR_SIGNED_EN selects two's-complement ordering; equality is mode-independent.
module comparator_core #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o
);

`ifdef COMPARATOR_SIGNED_EN
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;

    assign a_s  = $signed(a_i);
    assign b_s  = $signed(b_i);
    assign gt_o = (a_s > b_s);
`else
    assign gt_o = (a_i > b_i);
`endif

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparator.sv
// Registered six-flag magnitude comparator with a one-cycle latency valid flag.
// Define COMPARATOR_SIGNED_EN for two's-complement operands (default unsigned).
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = COMPARATOR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dec_a_in,
    input  logic [WIDTH-1:0] dec_b_in,
    output logic             out_valid,
    output logic             a_gt_b,
    output logic             a_ge_b,
    output logic             a_lt_b,
    output logic             a_le_b,
    output logic             a_eq_b,
    output logic             a_ne_b
);

    logic       gt_c;
    logic       eq_c;
    cmp_flags_t flags_c;
    cmp_flags_t flags_d;
    cmp_flags_t flags_q;
    logic       valid_d;
    logic       valid_q;

    comparator_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i  (dec_a_in),
        .b_i  (dec_b_in),
        .gt_o (gt_c),
        .eq_o (eq_c)
    );

    assign flags_c = derive_flags(gt_c, eq_c);

    // Flags only update on a valid compare; otherwise they hold the last result.
    always_comb begin
        flags_d = flags_q;
        valid_d = in_valid;
        if (in_valid) begin
            flags_d = flags_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= CMP_FLAGS_CLEAR;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign a_gt_b    = flags_q.gt;
    assign a_ge_b    = flags_q.ge;
    assign a_lt_b    = flags_q.lt;
    assign a_le_b    = flags_q.le;
    assign a_eq_b    = flags_q.eq;
    assign a_ne_b    = flags_q.ne;

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for the registered comparator (honours COMPARATOR_SIGNED_EN).
module tb_comparator;

    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] dec_a_in;
    logic [W-1:0] dec_b_in;
    logic         out_valid;
    logic         a_gt_b, a_ge_b, a_lt_b, a_le_b, a_eq_b, a_ne_b;

    int checks   = 0;
    int failures = 0;

    // Expected vector layout: {valid, gt, ge, lt, le, eq, ne}
    logic [6:0] sb[$];
    logic [5:0] model_flags = '0;

    comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .dec_a_in  (dec_a_in),
        .dec_b_in  (dec_b_in),
        .out_valid (out_valid),
        .a_gt_b    (a_gt_b),
        .a_ge_b    (a_ge_b),
        .a_lt_b    (a_lt_b),
        .a_le_b    (a_le_b),
        .a_eq_b    (a_eq_b),
        .a_ne_b    (a_ne_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int to_int(input logic [W-1:0] v);
        int r;
        r = int'(v);
`ifdef COMPARATOR_SIGNED_EN
        if (v[W-1]) r = r - (1 << W);
`endif
        return r;
    endfunction

    function automatic logic [6:0] observed();
        return {out_valid, a_gt_b, a_ge_b, a_lt_b, a_le_b, a_eq_b, a_ne_b};
    endfunction

    // Predict the registered result of this edge, queue it, then apply and clock.
    task automatic drive(input logic rstn, input logic vld,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
        logic [6:0] e;
        ia = to_int(a);
        ib = to_int(b);
        if (!rstn) begin
            model_flags = '0;
            e = 7'b0;
        end else if (vld) begin
            model_flags = {ia > ib, ia >= ib, ia < ib, ia <= ib, ia == ib, ia != ib};
            e = {1'b1, model_flags};
        end else begin
            e = {1'b0, model_flags};
        end
        sb.push_back(e);
        rst_n    = rstn;
        in_valid = vld;
        dec_a_in = a;
        dec_b_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'd5, 3'd2);
            e = sb.pop_front();
            checks++;
            if (observed() !== 7'b0 || e !== 7'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, observed(), 7'b0);
            end
        end
        drive(1'b1, 1'b1, 3'd5, 3'd2);
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", observed(), e);
        end
`ifndef COMPARATOR_SIGNED_EN
        checks++;
        if (observed() !== 7'b1110001) begin
            failures++;
            $display("FAIL reset_release_5gt2 got=%b want=%b", observed(), 7'b1110001);
        end
`endif
    endtask

    task automatic test_sweep();
        logic [6:0] e, o;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                drive(1'b1, 1'b1, W'(a), W'(b));
                e = sb.pop_front();
                o = observed();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL sweep a=%0d b=%0d got=%b want=%b", a, b, o, e);
                end
                checks++;
                if (!out_valid || ($countones({a_gt_b, a_eq_b, a_lt_b}) != 1) ||
                    (a_ge_b !== ~a_lt_b) || (a_le_b !== ~a_gt_b) || (a_ne_b !== ~a_eq_b)) begin
                    failures++;
                    $display("FAIL invariants a=%0d b=%0d got=%b want=consistent_valid", a, b, o);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [6:0] e;
        logic [W-1:0] av[3];
        logic [W-1:0] bv[3];
        logic [6:0]   uv[3];
        av = '{3'd0, 3'd7, 3'd7};
        bv = '{3'd7, 3'd7, 3'd0};
        uv = '{7'b1001101, 7'b1010110, 7'b1110001};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, av[i], bv[i]);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL boundary_model i=%0d got=%b want=%b", i, observed(), e);
            end
`ifndef COMPARATOR_SIGNED_EN
            checks++;
            if (observed() !== uv[i]) begin
                failures++;
                $display("FAIL boundary_const i=%0d got=%b want=%b", i, observed(), uv[i]);
            end
`endif
        end
    endtask

    task automatic test_valid_gaps();
        logic [6:0] e;
        logic [3:0] vpat;
        drive(1'b1, 1'b1, 3'd3, 3'd3);
        vpat[3] = out_valid;
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL gap_first got=%b want=%b", observed(), e);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 3'd0, 3'd7);
            vpat[2-i] = out_valid;
            e = sb.pop_front();
            checks++;
            if (observed() !== e || observed() !== 7'b0010110) begin
                failures++;
                $display("FAIL gap_hold cyc=%0d got=%b want=%b", i, observed(), 7'b0010110);
            end
        end
        drive(1'b1, 1'b1, 3'd1, 3'd6);
        vpat[0] = out_valid;
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL gap_resume got=%b want=%b", observed(), e);
        end
`ifndef COMPARATOR_SIGNED_EN
        checks++;
        if (a_lt_b !== 1'b1) begin
            failures++;
            $display("FAIL gap_resume_lt got=%b want=1", a_lt_b);
        end
`endif
        checks++;
        if (vpat !== 4'b1001) begin
            failures++;
            $display("FAIL gap_valid_pattern got=%b want=1001", vpat);
        end
    endtask

    task automatic test_signed();
        logic [6:0] e;
        logic [W-1:0] av[3];
        logic [W-1:0] bv[3];
        logic [6:0]   xv[3];
        av = '{3'b111, 3'b100, 3'b011};
        bv = '{3'b000, 3'b011, 3'b101};
`ifdef COMPARATOR_SIGNED_EN
        xv = '{7'b1001101, 7'b1001101, 7'b1110001};
`else
        xv = '{7'b1110001, 7'b1110001, 7'b1001101};
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, av[i], bv[i]);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL sign_model i=%0d got=%b want=%b", i, observed(), e);
            end
            checks++;
            if (observed() !== xv[i]) begin
                failures++;
                $display("FAIL sign_const i=%0d got=%b want=%b", i, observed(), xv[i]);
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [6:0] e;
        for (int i = 0; i < 8; i++) begin
            logic r;
            logic [W-1:0] a, b;
            r = (i != 4);
            a = W'($urandom_range(0, 7));
            b = W'($urandom_range(0, 7));
            drive(r, 1'b1, a, b);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL midreset cyc=%0d a=%0d b=%0d got=%b want=%b", i, a, b, observed(), e);
            end
            if (!r) begin
                checks++;
                if (observed() !== 7'b0) begin
                    failures++;
                    $display("FAIL midreset_clear got=%b want=0000000", observed());
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        dec_a_in = '0;
        dec_b_in = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_sweep();
        test_boundary();
        test_valid_gaps();
        test_signed();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
